// File: rtl/rms_div_sqrt_pipe_pkg.sv
// rtl/rms_div_sqrt_pipe_pkg.sv - shared widths, stage counts and divider step helper
package rms_div_sqrt_pipe_pkg;

    localparam int DIVIDEND_W  = 72;
    localparam int DIVISOR_W   = 10;
    localparam int ROOT_W      = 32;
    localparam int RAD_W       = 2 * ROOT_W;
    localparam int DIV_STAGES  = 36;
    localparam int ROOT_STAGES = 32;
    localparam int LATENCY     = DIV_STAGES + ROOT_STAGES;

    typedef struct packed {
        logic [DIVISOR_W-1:0] rem;
        logic                 qbit;
    } div_step_t;

    // One restoring long-division step. A zero divisor always "fits", so the
    // quotient naturally saturates to all ones without a special case.
    function automatic div_step_t div_step(
        input logic [DIVISOR_W-1:0] rem,
        input logic                 din,
        input logic [DIVISOR_W-1:0] den
    );
        logic [DIVISOR_W:0] trial;
        logic [DIVISOR_W:0] diff;
        div_step_t          res;
        trial = {rem, din};
        diff  = trial - {1'b0, den};
        if (trial >= {1'b0, den}) begin
            res.qbit = 1'b1;
            res.rem  = diff[DIVISOR_W-1:0];
        end else begin
            res.qbit = 1'b0;
            res.rem  = trial[DIVISOR_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/rds_vld_dff.sv
// rtl/rds_vld_dff.sv - single-bit flop with synchronous active-high clear
module rds_vld_dff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    // One tap of the valid delay line.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/rms_div_sqrt_pipe.sv
// rtl/rms_div_sqrt_pipe.sv - pipelined floor(sqrt(floor(dividend/divisor) mod 2^64))
module rms_div_sqrt_pipe
    import rms_div_sqrt_pipe_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    output logic [ROOT_W-1:0]     root,
    output logic                  div_by_zero
);

    // Stage registers: index k is the output register of stage k.
    logic [DIVIDEND_W-1:0] div_work [DIV_STAGES];
    logic [DIVISOR_W-1:0]  div_rem  [DIV_STAGES];
    logic [DIVISOR_W-1:0]  div_den  [DIV_STAGES];
    logic [RAD_W-1:0]      rt_rad   [ROOT_STAGES];
    logic [ROOT_W+1:0]     rt_rem   [ROOT_STAGES];
    logic [ROOT_W-1:0]     rt_root  [ROOT_STAGES];
    logic                  dz_q     [LATENCY];
    logic                  vld_q    [LATENCY];

    // Divider: each stage retires two quotient bits. The working register
    // shifts dividend bits out of the top and quotient bits in at the bottom,
    // so after the last stage it holds the full 72-bit quotient.
    for (genvar s = 0; s < DIV_STAGES; s++) begin : g_div
        logic [DIVIDEND_W-1:0] work_in;
        logic [DIVISOR_W-1:0]  rem_in;
        logic [DIVISOR_W-1:0]  den_in;
        logic                  dz_in;
        div_step_t             hi_step;
        div_step_t             lo_step;
        logic [DIVIDEND_W-1:0] work_next;

        if (s == 0) begin : g_src
            assign work_in = dividend;
            assign rem_in  = '0;
            assign den_in  = divisor;
            assign dz_in   = (divisor == '0);
        end else begin : g_src
            assign work_in = div_work[s-1];
            assign rem_in  = div_rem[s-1];
            assign den_in  = div_den[s-1];
            assign dz_in   = dz_q[s-1];
        end

        // Two chained restoring steps per stage.
        always_comb begin
            hi_step   = div_step(rem_in, work_in[DIVIDEND_W-1], den_in);
            lo_step   = div_step(hi_step.rem, work_in[DIVIDEND_W-2], den_in);
            work_next = {work_in[DIVIDEND_W-3:0], hi_step.qbit, lo_step.qbit};
        end

        // Divider stage register.
        always_ff @(posedge clk) begin
            if (rst) begin
                div_work[s] <= '0;
                div_rem[s]  <= '0;
                div_den[s]  <= '0;
                dz_q[s]     <= 1'b0;
            end else begin
                div_work[s] <= work_next;
                div_rem[s]  <= lo_step.rem;
                div_den[s]  <= den_in;
                dz_q[s]     <= dz_in;
            end
        end
    end

    // Square root: restoring digit-by-digit, one root bit per stage, consuming
    // two radicand bits per stage. Only the low 64 quotient bits enter here.
    for (genvar t = 0; t < ROOT_STAGES; t++) begin : g_root
        logic [RAD_W-1:0]  rad_in;
        logic [ROOT_W+1:0] rem_in;
        logic [ROOT_W-1:0] root_in;
        logic              dz_in;
        logic [ROOT_W+3:0] acc;
        logic [ROOT_W+3:0] trial;
        logic [ROOT_W+3:0] diff;
        logic [ROOT_W+1:0] rem_next;
        logic [ROOT_W-1:0] root_next;

        if (t == 0) begin : g_src
            assign rad_in  = div_work[DIV_STAGES-1][RAD_W-1:0];
            assign rem_in  = '0;
            assign root_in = '0;
        end else begin : g_src
            assign rad_in  = rt_rad[t-1];
            assign rem_in  = rt_rem[t-1];
            assign root_in = rt_root[t-1];
        end
        assign dz_in = dz_q[DIV_STAGES+t-1];

        // Try subtracting 4*root+1; keep the difference only if it fits.
        always_comb begin
            acc   = {rem_in, rad_in[RAD_W-1 -: 2]};
            trial = {2'b00, root_in, 2'b01};
            diff  = acc - trial;
            if (acc >= trial) begin
                rem_next  = diff[ROOT_W+1:0];
                root_next = {root_in[ROOT_W-2:0], 1'b1};
            end else begin
                rem_next  = acc[ROOT_W+1:0];
                root_next = {root_in[ROOT_W-2:0], 1'b0};
            end
        end

        // Root stage register.
        always_ff @(posedge clk) begin
            if (rst) begin
                rt_rad[t]             <= '0;
                rt_rem[t]             <= '0;
                rt_root[t]            <= '0;
                dz_q[DIV_STAGES+t]    <= 1'b0;
            end else begin
                rt_rad[t]             <= {rad_in[RAD_W-3:0], 2'b00};
                rt_rem[t]             <= rem_next;
                rt_root[t]            <= root_next;
                dz_q[DIV_STAGES+t]    <= dz_in;
            end
        end
    end

    // Valid delay line, one flop per data stage.
    for (genvar v = 0; v < LATENCY; v++) begin : g_vld
        if (v == 0) begin : g_tap
            rds_vld_dff u_dff (.clk(clk), .rst(rst), .d(in_valid), .q(vld_q[v]));
        end else begin : g_tap
            rds_vld_dff u_dff (.clk(clk), .rst(rst), .d(vld_q[v-1]), .q(vld_q[v]));
        end
    end

    assign out_valid   = vld_q[LATENCY-1];
    assign root        = rt_root[ROOT_STAGES-1];
    assign div_by_zero = dz_q[LATENCY-1];

endmodule

// File: tb/tb_rms_div_sqrt_pipe.sv
// tb/tb_rms_div_sqrt_pipe.sv - bench for rms_div_sqrt_pipe
module tb_rms_div_sqrt_pipe;
    import rms_div_sqrt_pipe_pkg::*;

    localparam int HMAX = 16384;
    localparam int LAT  = 68;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  out_valid;
    logic [ROOT_W-1:0]     root;
    logic                  div_by_zero;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic                  hist_v [HMAX];
    logic                  hist_r [HMAX];
    logic [DIVIDEND_W-1:0] hist_a [HMAX];
    logic [DIVISOR_W-1:0]  hist_b [HMAX];

    rms_div_sqrt_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .dividend(dividend),
        .divisor(divisor), .out_valid(out_valid), .root(root), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: integer division, keep 64 LSBs, integer square root by bisection.
    function automatic logic [31:0] ref_root(input logic [71:0] a, input logic [9:0] b);
        logic [71:0] q;
        logic [63:0] x;
        logic [32:0] lo, hi, mid;
        logic [65:0] sq;
        q  = (b == 10'd0) ? {72{1'b1}} : a / {62'd0, b};
        x  = q[63:0];
        lo = 33'd0;
        hi = 33'h1_0000_0000;
        while (hi - lo > 33'd1) begin
            mid = (lo + hi) >> 1;
            sq  = mid * mid;
            if (sq <= {2'b00, x}) lo = mid;
            else hi = mid;
        end
        return lo[31:0];
    endfunction

    task automatic step(input logic v, input logic [71:0] a, input logic [9:0] b, input logic r);
        in_valid = v;
        dividend = a;
        divisor  = b;
        rst      = r;
        hist_v[cyc] = v;
        hist_a[cyc] = a;
        hist_b[cyc] = b;
        hist_r[cyc] = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_until(input int target);
        logic [95:0] rnd;
        while (cyc < target) begin
            rnd = {$urandom, $urandom, $urandom};
            step(1'b0, rnd[71:0], rnd[81:72], 1'b0);
        end
    endtask

    // Every cycle: out_valid must follow the model's surviving operations;
    // root/div_by_zero are checked whenever a result is expected.
    always @(negedge clk) begin
        int  m;
        int  s;
        logic ev;
        if (cyc >= 1 && cyc < HMAX) begin
            m  = cyc - 1;
            s  = m - (LAT - 1);
            ev = 1'b0;
            if (s >= 0) begin
                ev = hist_v[s];
                for (int k = s; k <= m; k++) if (hist_r[k]) ev = 1'b0;
            end
            check("out_valid_stream", 72'(out_valid), 72'(ev));
            if (ev) begin
                check("root_stream", 72'(root), 72'(ref_root(hist_a[s], hist_b[s])));
                check("dz_stream", 72'(div_by_zero), 72'(hist_b[s] == 10'd0));
            end
        end
    end

    initial begin
        int n;
        logic [95:0] rnd;
        logic [71:0] a;
        logic [9:0]  b;
        logic        v;

        // Reset state.
        step(1'b1, 72'd0, 10'd0, 1'b1);
        step(1'b1, 72'd5, 10'd0, 1'b1);
        check("reset_valid", 72'(out_valid), 72'd0);
        check("reset_root", 72'(root), 72'd0);
        check("reset_dz", 72'(div_by_zero), 72'd0);
        idle_until(cyc + 3);

        // Single op latency.
        n = cyc;
        step(1'b1, 72'd400, 10'd4, 1'b0);
        idle_until(n + LAT - 1);
        check("single_prev_valid", 72'(out_valid), 72'd0);
        idle_until(n + LAT);
        check("single_valid", 72'(out_valid), 72'd1);
        check("single_root", 72'(root), 72'd10);
        check("single_dz", 72'(div_by_zero), 72'd0);
        idle_until(n + LAT + 1);
        check("single_next_valid", 72'(out_valid), 72'd0);

        // Back-to-back ops.
        n = cyc;
        step(1'b1, 72'd1000, 10'd3, 1'b0);
        step(1'b1, {8'd0, {64{1'b1}}}, 10'd1, 1'b0);
        step(1'b1, 72'd81, 10'd1, 1'b0);
        idle_until(n + LAT);
        check("b2b_root0", 72'(root), 72'd18);
        idle_until(n + LAT + 1);
        check("b2b_root1", 72'(root), 72'hFFFF_FFFF);
        check("b2b_valid1", 72'(out_valid), 72'd1);
        idle_until(n + LAT + 2);
        check("b2b_root2", 72'(root), 72'd9);

        // Divide by zero, truncated quotient, zero dividend.
        n = cyc;
        step(1'b1, 72'd12345, 10'd0, 1'b0);
        a = 72'd1 << 66;
        step(1'b1, a, 10'd2, 1'b0);
        step(1'b1, 72'd0, 10'd7, 1'b0);
        idle_until(n + LAT);
        check("dz_root", 72'(root), 72'hFFFF_FFFF);
        check("dz_flag", 72'(div_by_zero), 72'd1);
        idle_until(n + LAT + 1);
        check("trunc_root", 72'(root), 72'd0);
        check("trunc_dz", 72'(div_by_zero), 72'd0);
        idle_until(n + LAT + 2);
        check("zero_div_root", 72'(root), 72'd0);

        // Mid-flight reset cancels everything in the pipe.
        n = cyc;
        for (int i = 0; i < 5; i++) step(1'b1, 72'd400 + 72'(i), 10'd3, 1'b0);
        idle_until(n + 30);
        step(1'b0, 72'd0, 10'd0, 1'b1);
        check("midrst_valid", 72'(out_valid), 72'd0);
        check("midrst_root", 72'(root), 72'd0);
        check("midrst_dz", 72'(div_by_zero), 72'd0);
        idle_until(n + 30 + LAT + 4);
        n = cyc;
        step(1'b1, 72'd144, 10'd1, 1'b0);
        idle_until(n + LAT);
        check("postrst_valid", 72'(out_valid), 72'd1);
        check("postrst_root", 72'(root), 72'd12);

        // Randomized traffic.
        for (int i = 0; i < 10000; i++) begin
            rnd = {$urandom, $urandom, $urandom};
            a   = rnd[71:0] >> $urandom_range(0, 71);
            if ($urandom_range(0, 19) == 0) a = {72{1'b1}};
            case ($urandom_range(0, 9))
                0:       b = 10'd1;
                1:       b = 10'd1023;
                2:       b = 10'd0;
                default: b = 10'($urandom);
            endcase
            v = ($urandom_range(0, 7) != 0);
            step(v, a, b, 1'b0);
        end
        idle_until(cyc + LAT + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rms_div_sqrt_pipe.md
RMS_DIV_SQRT_PIPE -- requirements
Module: rms_div_sqrt_pipe

Interface
REQ-001 Parameter DIVIDEND_W, 72, unsigned dividend width (accumulated sum of squares).
REQ-002 Parameter DIVISOR_W, 10, unsigned divisor width (sample count).
REQ-003 Parameter ROOT_W, 32, root width; square-root operand is the 2*ROOT_W = 64 LSBs of the quotient.
REQ-004 Parameter LATENCY, 68, register stages from the input sample to the output (36 divide + 32 root).
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 in_valid  input  1  operands valid this cycle (RMS result request).
REQ-008 dividend  input  DIVIDEND_W  unsigned sum.
REQ-009 divisor  input  DIVISOR_W  unsigned count.
REQ-010 out_valid  output  1  root valid; this is in_valid delayed by LATENCY.
REQ-011 root  output  ROOT_W  floor(sqrt(quotient[63:0])).
REQ-012 div_by_zero  output  1  the matching divisor was 0; aligned with root.

Function
REQ-013 The block SHALL compute q = floor(dividend/divisor) unsigned at full DIVIDEND_W width, then root = floor(sqrt(q[63:0])); q[71:64] SHALL be discarded.
REQ-014 The pipeline SHALL be fully pipelined with no stall or enable: it advances every cycle and accepts one operation per cycle, back-to-back.
REQ-015 Operands sampled at edge N SHALL drive root, div_by_zero and out_valid from edge N+67 onward (68 registers), so a consumer samples them at edge N+68.
REQ-016 The in_valid delay line SHALL be exactly LATENCY single-bit registers, aligned with the data path.
REQ-017 divisor = 0 SHALL produce q = all ones (2^72-1), root = 32'hFFFF_FFFF and div_by_zero = 1.
REQ-018 Data SHALL flow whether or not in_valid is set; root is meaningful only while out_valid = 1, and consumers SHALL qualify root with out_valid.
REQ-019 dividend = 0 with divisor != 0 SHALL give root = 0; no intermediate truncation is allowed other than the rule in REQ-013.

Reset
REQ-020 When rst = 1 at an edge, every pipeline register SHALL clear to 0: out_valid = 0, root = 0 and div_by_zero = 0 from that edge.
REQ-021 Reset asserted mid-flight SHALL cancel every in-flight operation; out_valid SHALL stay 0 until LATENCY edges after the first in_valid sampled after reset release.
REQ-022 in_valid sampled in the same edge as rst = 1 SHALL be ignored.

Structure
REQ-023 A shared package SHALL hold DIVIDEND_W, DIVISOR_W, ROOT_W, the divider stage count (36), the root stage count (32) and LATENCY.
REQ-024 The divider SHALL be a restoring array of 36 registered stages covering 72 quotient bits (2 bits per stage).
REQ-025 The root SHALL be a non-restoring/restoring array of 32 registered stages, one root bit per stage.
REQ-026 One sub-module, rds_vld_dff (1-bit sync-reset flop), SHALL be instantiated LATENCY times in a generate loop to form the valid delay line.

Verification
REQ-027 dividend=400, divisor=4, in_valid at edge N -> out_valid=1, root=10, div_by_zero=0 at edge N+68; out_valid=0 at edges N+67 and N+69.
REQ-028 Back-to-back edges N, N+1, N+2 with (1000,3), (2^64-1,1), (81,1) -> roots 18, 32'hFFFF_FFFF, 9 on consecutive edges N+68..N+70.
REQ-029 dividend=12345, divisor=0 -> root=32'hFFFF_FFFF, div_by_zero=1 at edge N+68.
REQ-030 dividend=2^66, divisor=2 (q=2^65, low 64 bits 0) -> root=0 at edge N+68.
REQ-031 Issue 5 ops, assert rst for 1 cycle at edge N+30 -> no out_valid pulse for those ops; a new op issued after reset returns correctly 68 edges later.
REQ-032 Randomized 10k ops checked against a reference model for floor(sqrt(floor(a/b) mod 2^64)), including b=1, b=1023 and a=2^72-1.
